// File: rtl/lpif_asym_pkg.sv
// Shared types and constants for the asym1 half-rate LPIF gearbox.
package lpif_asym_pkg;

    localparam int unsigned BEAT_W = 75;
    localparam int unsigned WORD_W = 2 * BEAT_W;

    // Bit offsets of each field inside a beat, LSB first
    localparam int unsigned STATE_OFF     = 0;
    localparam int unsigned PROTID_OFF    = 4;
    localparam int unsigned DATA_OFF      = 6;
    localparam int unsigned DVALID_OFF    = 70;
    localparam int unsigned CRC_OFF       = 71;
    localparam int unsigned CRC_VALID_OFF = 73;
    localparam int unsigned VALID_OFF     = 74;

    // Packed MSB first, so state ends up at bit 0
    typedef struct packed {
        logic        valid;
        logic        crc_valid;
        logic [1:0]  crc;
        logic        dvalid;
        logic [63:0] data;
        logic [1:0]  protid;
        logic [3:0]  state;
    } lpif_beat_t;

    // RxHigh: a word is registered, its beat0 is on the bus, beat1 still pending
    typedef enum logic {
        RxIdle = 1'b0,
        RxHigh = 1'b1
    } rx_state_e;

endpackage

// File: rtl/lpif_beat_unpacker.sv
// Splits each 150-bit RX FIFO word into two consecutive full-rate beats.
module lpif_beat_unpacker
    import lpif_asym_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              link_online,
    input  logic [WORD_W-1:0] word,
    input  logic              word_vld,
    output lpif_beat_t        beat,
    output logic              overrun
);

    rx_state_e         state_q, state_d;
    logic [WORD_W-1:0] word_q;
    logic              show_hi_q;
    logic              overrun_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RxIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any accepted word puts its beat0 on the bus next cycle
    always_comb begin
        state_d = RxIdle;
        if (link_online) begin
            case (state_q)
                RxIdle:  state_d = word_vld ? RxHigh : RxIdle;
                RxHigh:  state_d = word_vld ? RxHigh : RxIdle;
                default: state_d = RxIdle;
            endcase
        end
    end

    // Word holding register, beat1-due flag and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q    <= '0;
            show_hi_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (!link_online) begin
            word_q    <= '0;
            show_hi_q <= 1'b0;
        end else begin
            if (word_vld) begin
                word_q <= word;
            end
            // A word arriving while beat0 is driven replaces the pending high half
            show_hi_q <= (state_q == RxHigh) && !word_vld;
            if (word_vld && (state_q == RxHigh)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Output: beat0 while RxHigh, beat1 the cycle after, otherwise idle zeros
    always_comb begin
        beat = '0;
        if (link_online) begin
            if (state_q == RxHigh) begin
                beat = word_q[0 +: BEAT_W];
            end else if (show_hi_q) begin
                beat = word_q[BEAT_W +: BEAT_W];
            end
        end
    end

    assign overrun = overrun_q;

endmodule

// File: rtl/lpif_txrx_x1_asym1_half_master_gearbox.sv
// Master-end LPIF gearbox: packs two full-rate TX beats per FIFO word and
// unpacks each RX FIFO word into two full-rate beats.
module lpif_txrx_x1_asym1_half_master_gearbox
    import lpif_asym_pkg::*;
(
    input  logic              clk_wr,
    input  logic              rst_wr,
    input  logic              link_online,
    input  logic [3:0]        dstrm_state,
    input  logic [1:0]        dstrm_protid,
    input  logic [63:0]       dstrm_data,
    input  logic              dstrm_dvalid,
    input  logic [1:0]        dstrm_crc,
    input  logic              dstrm_crc_valid,
    input  logic              dstrm_valid,
    output logic [WORD_W-1:0] txfifo_downstream_data,
    output logic              txfifo_downstream_vld,
    input  logic [WORD_W-1:0] rxfifo_upstream_data,
    input  logic              rxfifo_upstream_vld,
    output logic [3:0]        ustrm_state,
    output logic [1:0]        ustrm_protid,
    output logic [63:0]       ustrm_data,
    output logic              ustrm_dvalid,
    output logic [1:0]        ustrm_crc,
    output logic              ustrm_crc_valid,
    output logic              ustrm_valid,
    output logic              tx_phase,
    output logic              rx_overrun
);

    logic [BEAT_W-1:0] tx_beat;
    logic [BEAT_W-1:0] hold_q;
    logic [WORD_W-1:0] tx_data_q;
    logic              tx_vld_q;
    logic              phase_q;
    lpif_beat_t        rx_beat;

    // Assemble the downstream beat in wire order
    always_comb begin
        tx_beat = '0;
        tx_beat[STATE_OFF +: 4]  = dstrm_state;
        tx_beat[PROTID_OFF +: 2] = dstrm_protid;
        tx_beat[DATA_OFF +: 64]  = dstrm_data;
        tx_beat[DVALID_OFF]      = dstrm_dvalid;
        tx_beat[CRC_OFF +: 2]    = dstrm_crc;
        tx_beat[CRC_VALID_OFF]   = dstrm_crc_valid;
        tx_beat[VALID_OFF]       = dstrm_valid;
    end

    // TX packer: phase0 beat goes to the hold register, phase1 beat completes the word
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            phase_q   <= 1'b0;
            hold_q    <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
        end else if (!link_online) begin
            // Dropping the phase discards any half-built pair
            phase_q  <= 1'b0;
            tx_vld_q <= 1'b0;
        end else if (!phase_q) begin
            hold_q   <= tx_beat;
            phase_q  <= 1'b1;
            tx_vld_q <= 1'b0;
        end else begin
            tx_data_q <= {tx_beat, hold_q};
            phase_q   <= 1'b0;
            tx_vld_q  <= 1'b1;
        end
    end

    assign txfifo_downstream_data = tx_data_q;
    assign txfifo_downstream_vld  = tx_vld_q;
    assign tx_phase               = phase_q;

    lpif_beat_unpacker u_unpacker (
        .clk         (clk_wr),
        .rst         (rst_wr),
        .link_online (link_online),
        .word        (rxfifo_upstream_data),
        .word_vld    (rxfifo_upstream_vld),
        .beat        (rx_beat),
        .overrun     (rx_overrun)
    );

    assign ustrm_state     = rx_beat.state;
    assign ustrm_protid    = rx_beat.protid;
    assign ustrm_data      = rx_beat.data;
    assign ustrm_dvalid    = rx_beat.dvalid;
    assign ustrm_crc       = rx_beat.crc;
    assign ustrm_crc_valid = rx_beat.crc_valid;
    assign ustrm_valid     = rx_beat.valid;

endmodule

// File: tb/tb_lpif_txrx_x1_asym1_half_master_gearbox.sv
// Bench for the master gearbox: vector table, directed corner sequences and
// random traffic against a queue/schedule reference model.
module tb_lpif_txrx_x1_asym1_half_master_gearbox;

    logic         clk_wr = 1'b0;
    logic         rst_wr;
    logic         link_online;
    logic [3:0]   dstrm_state;
    logic [1:0]   dstrm_protid;
    logic [63:0]  dstrm_data;
    logic         dstrm_dvalid;
    logic [1:0]   dstrm_crc;
    logic         dstrm_crc_valid;
    logic         dstrm_valid;
    logic [149:0] txfifo_downstream_data;
    logic         txfifo_downstream_vld;
    logic [149:0] rxfifo_upstream_data;
    logic         rxfifo_upstream_vld;
    logic [3:0]   ustrm_state;
    logic [1:0]   ustrm_protid;
    logic [63:0]  ustrm_data;
    logic         ustrm_dvalid;
    logic [1:0]   ustrm_crc;
    logic         ustrm_crc_valid;
    logic         ustrm_valid;
    logic         tx_phase;
    logic         rx_overrun;

    lpif_txrx_x1_asym1_half_master_gearbox dut (
        .clk_wr                 (clk_wr),
        .rst_wr                 (rst_wr),
        .link_online            (link_online),
        .dstrm_state            (dstrm_state),
        .dstrm_protid           (dstrm_protid),
        .dstrm_data             (dstrm_data),
        .dstrm_dvalid           (dstrm_dvalid),
        .dstrm_crc              (dstrm_crc),
        .dstrm_crc_valid        (dstrm_crc_valid),
        .dstrm_valid            (dstrm_valid),
        .txfifo_downstream_data (txfifo_downstream_data),
        .txfifo_downstream_vld  (txfifo_downstream_vld),
        .rxfifo_upstream_data   (rxfifo_upstream_data),
        .rxfifo_upstream_vld    (rxfifo_upstream_vld),
        .ustrm_state            (ustrm_state),
        .ustrm_protid           (ustrm_protid),
        .ustrm_data             (ustrm_data),
        .ustrm_dvalid           (ustrm_dvalid),
        .ustrm_crc              (ustrm_crc),
        .ustrm_crc_valid        (ustrm_crc_valid),
        .ustrm_valid            (ustrm_valid),
        .tx_phase               (tx_phase),
        .rx_overrun             (rx_overrun)
    );

    always #5 clk_wr = ~clk_wr;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [74:0]  txq[$];
    bit           m_tx_vld;
    logic [149:0] m_tx_data;
    logic [74:0]  slot_b[4];
    bit           slot_v[4];
    int           cyc;
    bit           m_ovr;
    bit           prev_acc;

    // Inputs applied in the current cycle
    bit           cur_r;
    bit           cur_on;
    logic [74:0]  cur_b;
    logic [149:0] cur_w;
    bit           cur_wv;

    typedef struct {
        bit          rst;
        bit          on;
        logic [63:0] dd;
        logic [63:0] rlo;
        logic [63:0] rhi;
        bit          rvld;
        bit          e_txvld;
        logic [63:0] e_lo;
        logic [63:0] e_hi;
        bit          e_uv;
        logic [63:0] e_ud;
        bit          e_ovr;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [149:0] act, input logic [149:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [74:0] mk(input logic [63:0] d);
        logic [74:0] b;
        b = '0;
        b[6 +: 64] = d;
        b[74] = 1'b1;
        return b;
    endfunction

    function automatic logic [74:0] ubeat();
        return {ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid, ustrm_data,
                ustrm_protid, ustrm_state};
    endfunction

    task automatic clear_slots();
        for (int i = 0; i < 4; i++) begin
            slot_v[i] = 1'b0;
            slot_b[i] = '0;
        end
    endtask

    // Apply one cycle of inputs and compare outputs against the model
    task automatic drive(input bit r, input bit on, input logic [74:0] b,
                         input logic [149:0] w, input bit wv, input bit en);
        logic [74:0] e_u;
        cur_r = r; cur_on = on; cur_b = b; cur_w = w; cur_wv = wv;
        rst_wr          = r;
        link_online     = on;
        dstrm_state     = b[3:0];
        dstrm_protid    = b[5:4];
        dstrm_data      = b[69:6];
        dstrm_dvalid    = b[70];
        dstrm_crc       = b[72:71];
        dstrm_crc_valid = b[73];
        dstrm_valid     = b[74];
        rxfifo_upstream_data = w;
        rxfifo_upstream_vld  = wv;
        #2;
        if (en) begin
            e_u = (on && slot_v[cyc % 4]) ? slot_b[cyc % 4] : '0;
            chk("model_tx_vld", 150'(txfifo_downstream_vld), 150'(m_tx_vld));
            chk("model_tx_data", txfifo_downstream_data, m_tx_data);
            chk("model_tx_phase", 150'(tx_phase), 150'(txq.size() == 1));
            chk("model_ustrm", 150'(ubeat()), 150'(e_u));
            chk("model_overrun", 150'(rx_overrun), 150'(m_ovr));
        end
    endtask

    // Clock edge: update the model with the inputs the DUT just sampled
    task automatic advance();
        @(posedge clk_wr);
        slot_v[cyc % 4] = 1'b0;
        if (cur_r) begin
            txq.delete();
            m_tx_vld  = 1'b0;
            m_tx_data = '0;
            clear_slots();
            m_ovr    = 1'b0;
            prev_acc = 1'b0;
        end else if (!cur_on) begin
            txq.delete();
            m_tx_vld = 1'b0;
            clear_slots();
            prev_acc = 1'b0;
        end else begin
            txq.push_back(cur_b);
            if (txq.size() == 2) begin
                m_tx_data = {txq[1], txq[0]};
                m_tx_vld  = 1'b1;
                txq.delete();
            end else begin
                m_tx_vld = 1'b0;
            end
            if (cur_wv) begin
                // Previous word's beat0 is on the bus now: its beat1 is lost
                if (prev_acc) m_ovr = 1'b1;
                slot_b[(cyc + 1) % 4] = cur_w[74:0];
                slot_v[(cyc + 1) % 4] = 1'b1;
                slot_b[(cyc + 2) % 4] = cur_w[149:75];
                slot_v[(cyc + 2) % 4] = 1'b1;
            end
            prev_acc = cur_wv;
        end
        cyc++;
        #1;
    endtask

    task automatic step(input bit r, input bit on, input logic [74:0] b,
                        input logic [149:0] w, input bit wv);
        drive(r, on, b, w, wv, 1'b1);
        advance();
    endtask

    initial begin
        logic [74:0]  w75;
        logic [149:0] exp_w;
        logic [95:0]  rb;
        logic [159:0] rw;

        cyc = 0; m_ovr = 0; prev_acc = 0; m_tx_vld = 0; m_tx_data = '0;
        clear_slots();

        //             rst on dd     rlo    rhi    rv etx elo ehi  uv ud     ovr
        tbl[0]  = '{1'b1, 1'b0, 64'h0, 64'h0,  64'h0,  1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0,  1'b0};
        tbl[1]  = '{1'b0, 1'b1, 64'h1, 64'h0,  64'h0,  1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0,  1'b0};
        tbl[2]  = '{1'b0, 1'b1, 64'h2, 64'hA,  64'hB,  1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0,  1'b0};
        tbl[3]  = '{1'b0, 1'b1, 64'h3, 64'h0,  64'h0,  1'b0, 1'b1, 64'h1, 64'h2, 1'b1, 64'hA,  1'b0};
        tbl[4]  = '{1'b0, 1'b1, 64'h4, 64'hC,  64'hD,  1'b1, 1'b0, 64'h1, 64'h2, 1'b1, 64'hB,  1'b0};
        tbl[5]  = '{1'b0, 1'b1, 64'h5, 64'h0,  64'h0,  1'b0, 1'b1, 64'h3, 64'h4, 1'b1, 64'hC,  1'b0};
        tbl[6]  = '{1'b0, 1'b1, 64'h6, 64'hE,  64'hF,  1'b1, 1'b0, 64'h3, 64'h4, 1'b1, 64'hD,  1'b0};
        tbl[7]  = '{1'b0, 1'b1, 64'h7, 64'h10, 64'h11, 1'b1, 1'b1, 64'h5, 64'h6, 1'b1, 64'hE,  1'b0};
        tbl[8]  = '{1'b0, 1'b1, 64'h8, 64'h0,  64'h0,  1'b0, 1'b0, 64'h5, 64'h6, 1'b1, 64'h10, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 64'h9, 64'h0,  64'h0,  1'b0, 1'b1, 64'h7, 64'h8, 1'b1, 64'h11, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 64'h0, 64'h0,  64'h0,  1'b0, 1'b0, 64'h7, 64'h8, 1'b0, 64'h0,  1'b1};

        // Initial reset with outputs still unknown
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        advance();

        // Table: TX pairing, spaced RX words, back-to-back RX overrun
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rst, tbl[i].on, mk(tbl[i].dd),
                  {mk(tbl[i].rhi), mk(tbl[i].rlo)}, tbl[i].rvld, 1'b1);
            exp_w = (tbl[i].e_lo == 0 && tbl[i].e_hi == 0) ? '0 :
                    {mk(tbl[i].e_hi), mk(tbl[i].e_lo)};
            chk($sformatf("tbl%0d_tx_vld", i), 150'(txfifo_downstream_vld), 150'(tbl[i].e_txvld));
            chk($sformatf("tbl%0d_tx_data", i), txfifo_downstream_data, exp_w);
            chk($sformatf("tbl%0d_ustrm", i), 150'(ubeat()),
                150'(tbl[i].e_uv ? mk(tbl[i].e_ud) : 75'd0));
            chk($sformatf("tbl%0d_overrun", i), 150'(rx_overrun), 150'(tbl[i].e_ovr));
            advance();
        end

        // Orphan beat discarded by link drop, next pair packs from phase0
        step(1'b0, 1'b0, mk(64'h0), '0, 1'b0);
        drive(1'b0, 1'b1, mk(64'h200), '0, 1'b0, 1'b1);
        chk("orphan_phase0", 150'(tx_phase), 150'(1'b0));
        advance();
        drive(1'b0, 1'b0, mk(64'h201), '0, 1'b0, 1'b1);
        chk("orphan_phase1", 150'(tx_phase), 150'(1'b1));
        advance();
        drive(1'b0, 1'b0, mk(64'h202), '0, 1'b0, 1'b1);
        chk("offline_phase", 150'(tx_phase), 150'(1'b0));
        chk("offline_vld", 150'(txfifo_downstream_vld), 150'(1'b0));
        advance();
        drive(1'b0, 1'b1, mk(64'h300), '0, 1'b0, 1'b1);
        chk("reonline_vld", 150'(txfifo_downstream_vld), 150'(1'b0));
        advance();
        drive(1'b0, 1'b1, mk(64'h400), '0, 1'b0, 1'b1);
        chk("reonline_phase", 150'(tx_phase), 150'(1'b1));
        advance();
        drive(1'b0, 1'b0, mk(64'h0), '0, 1'b0, 1'b1);
        chk("reonline_pair_vld", 150'(txfifo_downstream_vld), 150'(1'b1));
        chk("reonline_pair_data", txfifo_downstream_data, {mk(64'h400), mk(64'h300)});
        advance();

        // Reset in the middle of an RX pair and a TX pair
        step(1'b0, 1'b1, mk(64'h500), {mk(64'h21), mk(64'h20)}, 1'b1);
        drive(1'b1, 1'b1, mk(64'h501), '0, 1'b0, 1'b1);
        chk("prerst_ustrm", 150'(ubeat()), 150'(mk(64'h20)));
        chk("prerst_overrun", 150'(rx_overrun), 150'(1'b1));
        chk("prerst_phase", 150'(tx_phase), 150'(1'b1));
        advance();
        drive(1'b0, 1'b1, mk(64'h0), '0, 1'b0, 1'b1);
        chk("rst_ustrm", 150'(ubeat()), 150'(0));
        chk("rst_overrun", 150'(rx_overrun), 150'(1'b0));
        chk("rst_phase", 150'(tx_phase), 150'(1'b0));
        chk("rst_tx_vld", 150'(txfifo_downstream_vld), 150'(1'b0));
        advance();
        step(1'b0, 1'b1, mk(64'h0), '0, 1'b0);

        // Walking one over every beat bit, both halves, TX and RX
        for (int k = 0; k < 75; k++) begin
            w75 = '0;
            w75[k] = 1'b1;
            exp_w = {w75, w75};
            step(1'b0, 1'b1, w75, exp_w, 1'b1);
            drive(1'b0, 1'b1, w75, '0, 1'b0, 1'b1);
            chk($sformatf("walk%0d_rx_lo", k), 150'(ubeat()), 150'(w75));
            advance();
            drive(1'b0, 1'b1, '0, '0, 1'b0, 1'b1);
            chk($sformatf("walk%0d_tx", k), txfifo_downstream_data, exp_w);
            chk($sformatf("walk%0d_rx_hi", k), 150'(ubeat()), 150'(w75));
            advance();
            step(1'b0, 1'b1, '0, '0, 1'b0);
        end

        // Random traffic, occasional resets and link drops
        for (int n = 0; n < 3000; n++) begin
            rb = {$urandom(), $urandom(), $urandom()};
            rw = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) != 0), rb[74:0],
                 rw[149:0], ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
